// File: rtl/pipe_pkg.sv
// Shared types for the hazard/forwarding unit: scoreboard entry layout,
// captured EX source operands, width defaults and the empty-slot constant.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 4;

    // Register numbers are held zero-extended to this width so the entry
    // type does not depend on the top's REG_AW (which must not exceed it).
    localparam int RG_MAX_W = 8;

    typedef logic [RG_MAX_W-1:0] sb_rg_t;

    // One in-flight instruction: does it exist, does it write, where, is it a load.
    typedef struct packed {
        logic   valid;
        logic   we;
        sb_rg_t rg;
        logic   load;
    } sb_entry_t;

    localparam sb_entry_t SB_NOP = '0;

    // Source operands of the instruction sitting in EX.
    typedef struct packed {
        logic   rp_used;
        sb_rg_t rp;
        logic   rs_used;
        sb_rg_t rs;
    } ex_src_t;

    localparam ex_src_t SRC_NONE = '0;

    // True when entry e is a real instruction that will write register r.
    function automatic logic sb_writes(input sb_entry_t e, input sb_rg_t r);
        return e.valid && e.we && (e.rg == r);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding match for one EX operand across the post-EX stages.
// The nearest (youngest) producer wins; a load is skipped while its data
// is still in flight (stage index <= LOAD_LAT).
module fwd_select
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1
) (
    input  sb_entry_t [FWD_STAGES-1:0]        post_ex,   // index k-1 = stage k
    input  logic                              src_used,
    input  sb_rg_t                            src_reg,
    input  logic      [FWD_STAGES*DATA_W-1:0] fwd_data,
    output logic                              fwd_en,
    output logic      [DATA_W-1:0]            fwd_value
);

    // Walk from the oldest stage to the youngest so the youngest hit is the last write.
    always_comb begin
        fwd_en    = 1'b0;
        fwd_value = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (src_used && sb_writes(post_ex[k-1], src_reg) &&
                !(post_ex[k-1].load && (k <= LOAD_LAT))) begin
                fwd_en    = 1'b1;
                fwd_value = fwd_data[(k-1)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding between Decode and Execute.
// Destination registers of in-flight instructions are tracked in an internal
// scoreboard shift pipeline (position 0 = EX, FWD_STAGES = WB).
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rp,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic                         id_rp_used,
    input  logic                         id_rs_used,
    input  logic [REG_AW-1:0]            id_rg,
    input  logic                         id_we,
    input  logic                         id_load,
    input  logic                         ex_branch_taken,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
    output logic                         fwd_a_en,
    output logic                         fwd_b_en,
    output logic [DATA_W-1:0]            fwd_a_data,
    output logic [DATA_W-1:0]            fwd_b_data,
    output logic                         stall_if_id,
    output logic                         bubble_id_ex,
    output logic                         flush_if_id
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                  perf_stalls,
    output logic [31:0]                  perf_flushes
`endif
);

    sb_entry_t sb_q [0:FWD_STAGES];
    sb_entry_t sb_d [0:FWD_STAGES];
    ex_src_t   src_q, src_d;

    sb_entry_t [FWD_STAGES-1:0] post_ex;
    logic                       load_use;
    logic                       kill_id;
    logic                       a_en, b_en;
    logic [DATA_W-1:0]          a_data, b_data;

    // Load-use: a used ID source matches a load whose data is not yet forwardable.
    always_comb begin
        load_use = 1'b0;
        for (int p = 0; p < LOAD_LAT; p++) begin
            if (sb_q[p].load &&
                ((id_rp_used && sb_writes(sb_q[p], sb_rg_t'(id_rp))) ||
                 (id_rs_used && sb_writes(sb_q[p], sb_rg_t'(id_rs))))) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && id_valid;
    end

    // The ID instruction is kept out of EX on a load-use hazard or a taken branch.
    assign kill_id = load_use || ex_branch_taken;

    // Outputs are forced low while reset is asserted; branch overrides the stall.
    assign stall_if_id  = rst_n && load_use && !ex_branch_taken;
    assign bubble_id_ex = rst_n && kill_id;
    assign flush_if_id  = rst_n && ex_branch_taken;
    assign fwd_a_en     = rst_n && a_en;
    assign fwd_b_en     = rst_n && b_en;
    assign fwd_a_data   = rst_n ? a_data : '0;
    assign fwd_b_data   = rst_n ? b_data : '0;

    // Next scoreboard: shift older entries on, admit the ID instruction unless killed.
    always_comb begin
        sb_d[0] = SB_NOP;
        src_d   = SRC_NONE;
        for (int k = 1; k <= FWD_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (!kill_id) begin
            sb_d[0].valid = id_valid;
            sb_d[0].we    = id_we;
            sb_d[0].rg    = sb_rg_t'(id_rg);
            sb_d[0].load  = id_load;
            src_d.rp_used = id_valid && id_rp_used;
            src_d.rp      = sb_rg_t'(id_rp);
            src_d.rs_used = id_valid && id_rs_used;
            src_d.rs      = sb_rg_t'(id_rs);
        end
    end

    // Scoreboard and EX source registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= FWD_STAGES; k++) begin
                sb_q[k] <= SB_NOP;
            end
            src_q <= SRC_NONE;
        end else begin
            for (int k = 0; k <= FWD_STAGES; k++) begin
                sb_q[k] <= sb_d[k];
            end
            src_q <= src_d;
        end
    end

    // Present post-EX positions to the operand selectors (index k-1 = stage k).
    always_comb begin
        for (int k = 1; k <= FWD_STAGES; k++) begin
            post_ex[k-1] = sb_q[k];
        end
    end

    fwd_select #(
        .DATA_W     (DATA_W),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT)
    ) u_fwd_a (
        .post_ex   (post_ex),
        .src_used  (src_q.rp_used),
        .src_reg   (src_q.rp),
        .fwd_data  (fwd_data),
        .fwd_en    (a_en),
        .fwd_value (a_data)
    );

    fwd_select #(
        .DATA_W     (DATA_W),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT)
    ) u_fwd_b (
        .post_ex   (post_ex),
        .src_used  (src_q.rs_used),
        .src_reg   (src_q.rs),
        .fwd_data  (fwd_data),
        .fwd_en    (b_en),
        .fwd_value (b_data)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    // Saturating event counts of stall and flush cycles.
    always_comb begin
        perf_stalls_d  = perf_stalls_q;
        perf_flushes_d = perf_flushes_q;
        if (stall_if_id && (perf_stalls_q != '1)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
        if (flush_if_id && (perf_flushes_q != '1)) begin
            perf_flushes_d = perf_flushes_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: default instance (FWD_STAGES=2, LOAD_LAT=1)
// plus a FWD_STAGES=3, LOAD_LAT=2 instance sharing the ID-side inputs.
// Valid/ready contract: one expected entry is queued per driven cycle; the
// monitor consumes exactly one entry at each falling edge while any remain.
module tb_hazard_forward_unit;

  localparam int W = 76;  // {chk_main, chk_l2, main[68:0], l2[4:0]}

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_rp, id_rs, id_rg;
  logic        id_rp_used, id_rs_used, id_we, id_load;
  logic        ex_branch_taken;
  logic [63:0] fwd_data;
  logic [95:0] l2_fwd_data;

  logic        fwd_a_en, fwd_b_en, stall_if_id, bubble_id_ex, flush_if_id;
  logic [31:0] fwd_a_data, fwd_b_data;
  logic        l2_a_en, l2_b_en, l2_stall, l2_bubble, l2_flush;
  logic [31:0] l2_a_data, l2_b_data;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stalls, perf_flushes, l2_perf_stalls, l2_perf_flushes;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  hazard_forward_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rp(id_rp), .id_rs(id_rs), .id_rp_used(id_rp_used), .id_rs_used(id_rs_used),
    .id_rg(id_rg), .id_we(id_we), .id_load(id_load),
    .ex_branch_taken(ex_branch_taken), .fwd_data(fwd_data),
    .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id)
`ifdef HAZARD_PERF_EN
    , .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
  );

  hazard_forward_unit #(.DATA_W(32), .REG_AW(4), .FWD_STAGES(3), .LOAD_LAT(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rp(id_rp), .id_rs(id_rs), .id_rp_used(id_rp_used), .id_rs_used(id_rs_used),
    .id_rg(id_rg), .id_we(id_we), .id_load(id_load),
    .ex_branch_taken(ex_branch_taken), .fwd_data(l2_fwd_data),
    .fwd_a_en(l2_a_en), .fwd_b_en(l2_b_en),
    .fwd_a_data(l2_a_data), .fwd_b_data(l2_b_data),
    .stall_if_id(l2_stall), .bubble_id_ex(l2_bubble), .flush_if_id(l2_flush)
`ifdef HAZARD_PERF_EN
    , .perf_stalls(l2_perf_stalls), .perf_flushes(l2_perf_flushes)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] rp, input logic rpu,
                        input logic [3:0] rs, input logic rsu, input logic [3:0] rg,
                        input logic we, input logic ld);
    id_valid = v; id_rp = rp; id_rp_used = rpu; id_rs = rs; id_rs_used = rsu;
    id_rg = rg; id_we = we; id_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [3:0] rg, input logic [3:0] rp, input logic [3:0] rs);
    set_id(1'b1, rp, 1'b1, rs, 1'b1, rg, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [3:0] rg);
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, rg, 1'b1, 1'b1);
  endtask

  task automatic set_fwd(input logic [31:0] s0, input logic [31:0] s1);
    fwd_data = {s1, s0};
  endtask

  // Expected default-instance outputs: a_en, a_data, b_en, b_data, stall, bubble, flush.
  task automatic exp_main(input string nm, input logic ae, input logic [31:0] ad,
                          input logic be, input logic [31:0] bd,
                          input logic st, input logic bu, input logic fl);
    exp_q.push_back({1'b1, 1'b0, ae, ad, be, bd, st, bu, fl, 5'd0});
    name_q.push_back(nm);
  endtask

  task automatic exp_zero(input string nm);
    exp_main(nm, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected second-instance {a_en, b_en, stall, bubble, flush}.
  task automatic exp_l2(input string nm, input logic [4:0] v);
    exp_q.push_back({1'b0, 1'b1, 69'd0, v});
    name_q.push_back(nm);
  endtask

  task automatic check_vec(input string nm, input logic [68:0] act, input logic [68:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;
  string        mon_nm;
  logic [68:0]  mon_act;
  logic [4:0]   mon_l2;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {fwd_a_en, fwd_a_data, fwd_b_en, fwd_b_data, stall_if_id, bubble_id_ex, flush_if_id};
      mon_l2  = {l2_a_en, l2_b_en, l2_stall, l2_bubble, l2_flush};
      if (mon_e[75]) begin
        n_cmp++;
        if (mon_act !== mon_e[73:5]) begin
          n_err++;
          $display("FAIL %s: got a_en=%0b a=%h b_en=%0b b=%h st=%0b bu=%0b fl=%0b, expected a_en=%0b a=%h b_en=%0b b=%h st=%0b bu=%0b fl=%0b",
                   mon_nm, mon_act[68], mon_act[67:36], mon_act[35], mon_act[34:3],
                   mon_act[2], mon_act[1], mon_act[0],
                   mon_e[73], mon_e[72:41], mon_e[40], mon_e[39:8], mon_e[7], mon_e[6], mon_e[5]);
        end
      end
      if (mon_e[74]) begin
        n_cmp++;
        if (mon_l2 !== mon_e[4:0]) begin
          n_err++;
          $display("FAIL %s: l2 {a_en,b_en,st,bu,fl} got %b, expected %b", mon_nm, mon_l2, mon_e[4:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    ex_branch_taken = 1'b0;
    fwd_data    = '0;
    l2_fwd_data = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};

    // Reset: outputs low even with a branch request present.
    next_cycle(); ex_branch_taken = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 69'd0, 5'd0}); name_q.push_back("in_reset");
    next_cycle(); rst_n = 1'b1; ex_branch_taken = 1'b0; exp_zero("reset_idle");

    // Back-to-back ALU: ADD R1 ; ADD R2,R1,R3.
    next_cycle(); alu(4'd1, 4'd2, 4'd3); exp_zero("alu_prod");
    next_cycle(); alu(4'd2, 4'd1, 4'd3); exp_zero("alu_cons_id");
    next_cycle(); idle(); set_fwd(32'h0000_0005, 32'h1111_1111);
    exp_main("alu_fwd_s1", 1'b1, 32'h0000_0005, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Distance 2: R1 ; independent ; consumer of R1.
    next_cycle(); alu(4'd1, 4'd6, 4'd7); set_fwd(32'd0, 32'd0); exp_zero("d2_prod");
    next_cycle(); alu(4'd8, 4'd9, 4'd10); exp_zero("d2_indep");
    next_cycle(); alu(4'd5, 4'd1, 4'd11); exp_zero("d2_cons_id");
    next_cycle(); idle(); set_fwd(32'h0000_0077, 32'hDEAD_BEEF);
    exp_main("d2_fwd_s2", 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Stages 1 and 2 both write R1: stage 1 wins.
    next_cycle(); alu(4'd1, 4'd12, 4'd13); set_fwd(32'd0, 32'd0); exp_zero("prio_prod_a");
    next_cycle(); alu(4'd1, 4'd14, 4'd15); exp_zero("prio_prod_b");
    next_cycle(); alu(4'd6, 4'd1, 4'd1); exp_zero("prio_cons_id");
    next_cycle(); idle(); set_fwd(32'hAAAA_0001, 32'hBBBB_0002);
    exp_main("prio_s1_wins", 1'b1, 32'hAAAA_0001, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);

    // Load-use: LOAD R4 ; ADD R5,R4,R4.
    next_cycle(); set_id(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1); set_fwd(32'd0, 32'd0);
    exp_zero("lu_load");
    next_cycle(); alu(4'd5, 4'd4, 4'd4);
    exp_main("lu_stall", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    next_cycle(); exp_zero("lu_release");
    next_cycle(); idle(); set_fwd(32'h1234_0000, 32'h0000_CAFE);
    exp_main("lu_fwd_s2", 1'b1, 32'h0000_CAFE, 1'b1, 32'h0000_CAFE, 1'b0, 1'b0, 1'b0);

    // Branch on the load-use cycle: flush wins, no stall.
    next_cycle(); load(4'd4); set_fwd(32'd0, 32'd0); exp_zero("br_load");
    next_cycle(); alu(4'd5, 4'd4, 4'd4); ex_branch_taken = 1'b1;
    exp_main("br_over_lu", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    next_cycle(); idle(); ex_branch_taken = 1'b0; exp_zero("br_after");

    // Producer without write enable: no forwarding, no stall.
    next_cycle(); set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 1'b0); exp_zero("nowe_prod");
    next_cycle(); alu(4'd8, 4'd7, 4'd7); exp_zero("nowe_cons_id");
    next_cycle(); idle(); set_fwd(32'h0000_5555, 32'h0000_6666); exp_zero("nowe_nofwd");
    next_cycle(); set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1); exp_zero("nowe_load");
    next_cycle(); set_id(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0); exp_zero("nowe_nostall");

    // Consumer with rp unused: A not forwarded, B (used) is.
    next_cycle(); set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0); exp_zero("unused_prod");
    next_cycle(); set_id(1'b1, 4'd10, 1'b0, 4'd10, 1'b1, 4'd0, 1'b0, 1'b0); exp_zero("unused_cons_id");
    next_cycle(); idle(); set_fwd(32'h0000_0099, 32'h0000_0077);
    exp_main("unused_a_used_b", 1'b0, 32'd0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0);

    // Second load-use, matched through rs.
    next_cycle(); load(4'd11); set_fwd(32'd0, 32'd0); exp_zero("lu2_load");
    next_cycle(); alu(4'd12, 4'd3, 4'd11);
    exp_main("lu2_stall_rs", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    next_cycle(); exp_zero("lu2_release");
    next_cycle(); load(4'd13); set_fwd(32'd0, 32'h0B0B_0B0B);
    exp_main("lu2_fwd_b", 1'b0, 32'd0, 1'b1, 32'h0B0B_0B0B, 1'b0, 1'b0, 1'b0);

    // Third load-use, back-to-back with the previous consumer.
    next_cycle(); set_id(1'b1, 4'd13, 1'b1, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0); set_fwd(32'd0, 32'd0);
    exp_main("lu3_stall", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    next_cycle(); exp_zero("lu3_release");
    next_cycle(); idle(); set_fwd(32'd0, 32'h0D0D_0D0D);
    exp_main("lu3_fwd_a", 1'b1, 32'h0D0D_0D0D, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
    check_vec("perf_stalls", {37'd0, perf_stalls}, 69'd3);
    check_vec("perf_flushes", {37'd0, perf_flushes}, 69'd1);
`endif

    // Reset asserted in the middle of a stall cycle.
    next_cycle(); load(4'd4); set_fwd(32'd0, 32'd0); exp_zero("rst_load");
    next_cycle(); alu(4'd5, 4'd4, 4'd4);
    exp_main("rst_pre_stall", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset_outputs",
              {fwd_a_en, fwd_a_data, fwd_b_en, fwd_b_data, stall_if_id, bubble_id_ex, flush_if_id},
              69'd0);
`ifdef HAZARD_PERF_EN
    check_vec("perf_reset", {5'd0, perf_stalls, perf_flushes}, 69'd0);
`endif
    next_cycle(); rst_n = 1'b1; exp_zero("rst_no_stale_stall");
    next_cycle(); idle(); set_fwd(32'h0000_4444, 32'h0000_5555); exp_zero("rst_no_stale_fwd");

    // Deeper instance: LOAD_LAT=2 gives two stall cycles, then forwarding from stage 3.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle();
    end
    next_cycle(); load(4'd4); exp_l2("l2_load", 5'b00000);
    next_cycle(); alu(4'd5, 4'd4, 4'd4); exp_l2("l2_stall_1", 5'b00110);
    next_cycle(); exp_l2("l2_stall_2", 5'b00110);
    next_cycle(); exp_l2("l2_release", 5'b00000);
    next_cycle(); idle(); exp_l2("l2_fwd_s3", 5'b11000);

    // Drain the expected queue within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
